// File: rtl/grid_result_streamer.sv
// Snapshots a completed sudoku grid and streams it one cell per valid/ready
// handshake in row-major order, followed by a single solved/unsolved status pulse.
module grid_result_streamer #(
    parameter  int GRID_ORD  = 3,
    localparam int GRID_LEN  = GRID_ORD * GRID_ORD,
    localparam int GRID_AREA = GRID_LEN * GRID_LEN,
    localparam int IDXW      = $clog2(GRID_AREA),
    localparam int DIGW      = $clog2(GRID_LEN + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          done_success,
    input  logic                          done_failure,
    input  logic [GRID_AREA*GRID_LEN-1:0] values,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDXW-1:0]               out_index,
    output logic [DIGW-1:0]               out_digit,
    output logic                          out_error,
    output logic                          out_last,
    output logic                          status_valid,
    output logic                          status_solved,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GRID_AREA - 1);

    state_t                        state;
    state_t                        state_next;
    logic [GRID_AREA*GRID_LEN-1:0] snapshot;
    logic [IDXW-1:0]               counter;
    logic [IDXW-1:0]               counter_next;
    logic [IDXW-1:0]               cell_sel;
    logic                          snap_load;
    logic                          cell_load;
    logic                          valid_next;
    logic                          status_valid_next;
    logic                          status_solved_next;
    logic [GRID_LEN-1:0]           cell_bits;
    logic [DIGW-1:0]               hot_count;
    logic [DIGW-1:0]               enc_digit;
    logic                          enc_error;
    logic                          handshake;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Failure outranks success in IDLE; done_* and clear are only heard in their own states.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (done_failure) begin
                    state_next = DONE;
                end else if (done_success) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = STREAM;
            STREAM: begin
                if (handshake && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        snap_load          = 1'b0;
        cell_load          = 1'b0;
        cell_sel           = counter;
        counter_next       = counter;
        valid_next         = 1'b0;
        status_valid_next  = 1'b0;
        status_solved_next = 1'b0;
        busy               = 1'b0;
        unique case (state)
            IDLE: begin
                if (done_failure) begin
                    status_valid_next = 1'b1;
                end else if (done_success) begin
                    snap_load = 1'b1;
                end
            end
            CAPTURE: begin
                busy         = 1'b1;
                counter_next = '0;
                cell_sel     = '0;
                cell_load    = 1'b1;
                valid_next   = 1'b1;
            end
            STREAM: begin
                busy       = 1'b1;
                valid_next = 1'b1;
                if (handshake) begin
                    if (out_last) begin
                        valid_next         = 1'b0;
                        status_valid_next  = 1'b1;
                        status_solved_next = 1'b1;
                    end else begin
                        counter_next = counter + 1'b1;
                        cell_sel     = counter + 1'b1;
                        cell_load    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (clear) begin
                    counter_next = '0;
                end
            end
            default: ;
        endcase
    end

    // Anything other than exactly one hot bit encodes as digit 0 with the error flag.
    always_comb begin
        cell_bits = snapshot[int'(cell_sel) * GRID_LEN +: GRID_LEN];
        hot_count = '0;
        enc_digit = '0;
        for (int k = 0; k < GRID_LEN; k++) begin
            if (cell_bits[k]) begin
                hot_count = hot_count + 1'b1;
                enc_digit = DIGW'(k + 1);
            end
        end
        enc_error = (hot_count != DIGW'(1));
        if (enc_error) begin
            enc_digit = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot      <= '0;
            counter       <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            out_digit     <= '0;
            out_error     <= 1'b0;
            out_last      <= 1'b0;
            status_valid  <= 1'b0;
            status_solved <= 1'b0;
        end else begin
            if (snap_load) begin
                snapshot <= values;
            end
            counter       <= counter_next;
            out_valid     <= valid_next;
            status_valid  <= status_valid_next;
            status_solved <= status_solved_next;
            if (cell_load) begin
                out_index <= cell_sel;
                out_digit <= enc_digit;
                out_error <= enc_error;
                out_last  <= (cell_sel == LAST_IDX);
            end
        end
    end

endmodule

// File: doc/grid_result_streamer.md
Name: grid_result_streamer

Overview:
- Sits directly downstream of the sudoku grid and consumes its completion flags and per-tile one-hot values.
- On completion it snapshots the whole grid and streams one cell per valid/ready handshake, in row-major order, as a binary digit.
- It then reports a single solved/unsolved status pulse.
- Decouples the grid from slow consumers such as a UART or display; the grid may be reset or restarted once the snapshot is taken.

Parameters:
- GRID_ORD, 3, block side length; GRID_LEN = GRID_ORD^2, GRID_AREA = GRID_LEN^2 (derived localparams).
- IDXW, $clog2(GRID_AREA), cell index width (derived).
- DIGW, $clog2(GRID_LEN+1), digit width; 0 = empty (derived).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- done_success  in  1  grid reports solution found (last tile passed forward).
- done_failure  in  1  grid reports no solution (first tile passed back).
- values  in  GRID_AREA*GRID_LEN  flattened row-major one-hot tile values; cell i occupies bits [i*GRID_LEN +: GRID_LEN].
- clear  in  1  consumer acknowledge; returns the block from DONE to IDLE.
- out_valid  out  1  stream cell valid.
- out_ready  in  1  consumer ready.
- out_index  out  IDXW  row-major cell index (r*GRID_LEN+c).
- out_digit  out  DIGW  binary digit 1..GRID_LEN, or 0 on error.
- out_error  out  1  the cell's snapshot value was not exactly one-hot.
- out_last  out  1  high with cell GRID_AREA-1.
- status_valid  out  1  one-cycle pulse when the run's outcome is final.
- status_solved  out  1  outcome; meaningful only while status_valid is high.
- busy  out  1  high in CAPTURE and STREAM.

Behaviour:
- Reset (async assert, sampled deassert): state=IDLE, all outputs 0, snapshot registers 0, index counter 0.
- FSM states: IDLE, CAPTURE, STREAM, DONE.
- IDLE:
  - done_failure=1: go to DONE; pulse status_valid=1, status_solved=0 on the next cycle. Failure wins if done_success is also high.
  - Else done_success=1: register the full values bus into the snapshot bank on that edge, then go to CAPTURE.
  - Else stay in IDLE.
- CAPTURE: one cycle; encode snapshot cell 0 into the output registers, go to STREAM. Latency from done_success sampled to out_valid=1 is 2 cycles.
- STREAM:
  - out_valid=1. Output fields come from registered encoding of snapshot cell [counter].
  - Handshake on out_valid&&out_ready. If counter<GRID_AREA-1, increment and present the next cell in the following cycle, with no bubble; sustained ready gives 1 cell/cycle.
  - out_valid, out_index, out_digit, out_error and out_last hold stable while out_valid&&!out_ready.
  - Handshake with out_last=1: go to DONE; out_valid=0 next cycle; status_valid=1, status_solved=1 for exactly one cycle, the first DONE cycle.
- DONE: outputs idle; clear=1 returns to IDLE and resets the counter. done_* inputs are ignored until back in IDLE.
- clear is ignored in IDLE, CAPTURE and STREAM. done_* and values changes are ignored in CAPTURE and STREAM, because the snapshot is isolated.
- Encoding per cell:
  - Exactly one bit k set: digit=k+1, error=0.
  - Zero bits or more than one bit set: digit=0, error=1.
  - Combinational popcount/priority over GRID_LEN bits is allowed; the result is registered.
- Counter wraps to 0 only through clear or reset, never by overflow.
- Reset mid-STREAM: immediate abort; out_valid drops asynchronously; no status pulse.
- Levels vs edges: done_* are levels. After clear, a done_success still held high triggers a new capture of current values; this is intended for repeat dumps.

Test Plan (GRID_ORD=2, GRID_LEN=4, GRID_AREA=16, DIGW=3, IDXW=4):
- Valid solved grid, row 0 values 4'b0001,0010,0100,1000, done_success pulse, out_ready tied 1. Required: out_valid rises 2 cycles later; 16 consecutive beats; cells 0..3 give digits 1,2,3,4; out_last only on index 15; status_valid=1, status_solved=1 one cycle after the last beat; busy falls with it.
- done_failure=1 in IDLE, also with done_success=1 in the same cycle. Required: no out_valid; status_valid pulse with status_solved=0; state DONE until clear.
- Backpressure: out_ready toggled 1,0,0,1 per cycle. Required: fields stable during stalls; indices 0..15 each seen exactly once, in order.
- Snapshot isolation: values driven to all-zero and done_success re-pulsed mid-STREAM. Required: the stream still emits the captured digits; no restart.
- Malformed cells: cell 5=4'b0000, cell 9=4'b0110. Required: those beats give digit 0 with out_error=1; all others out_error=0; status_solved=1 still.
- Reset asserted at the beat with index 7 while out_ready=0. Required: out_valid=0 immediately; no status pulse; a new done_success restarts from index 0.
